window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
// - Producer for calculate_median: turns a raster pixel stream into 3x3 windows p0..p8.
// - Two IMG_W-deep line buffers plus a 3x3 register window, with valid/ready on both sides.
// - Emits one window per interior pixel: (IMG_W-2)*(IMG_H-2) windows per frame, no border padding.
// PARAMETERS
// - DATA_W  8    pixel width in bits
// - IMG_W   640  pixels per line, >= 3
// - IMG_H   480  lines per frame, >= 3
// PORTS
// - clk      in   1          single clock, rising edge
// - rst_n    in   1          synchronous reset, active low
// - s_valid  in   1          input pixel valid
// - s_ready  out  1          input pixel accepted when s_valid && s_ready
// - s_sof    in   1          qualifies the accepted pixel as frame start (0,0)
// - s_data   in   DATA_W     input pixel, raster order
// - m_valid  out  1          window valid
// - m_ready  in   1          window consumed when m_valid && m_ready
// - p0..p8   out  DATA_W     window, row-major: p0 = top-left, p4 = centre, p8 = bottom-right
// - m_eol    out  1          window is the last one of its line (centre col IMG_W-2)
// - win_cnt  out  32         windows emitted this frame (only with WIN_CNT_EN)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): m_valid=0, m_eol=0, p0..p8=0, col=row=0, win_cnt=0.
//   s_ready=0 while rst_n=0. Line buffer RAM is not reset; stale data never reaches outputs.
// - s_ready = !m_valid || m_ready (combinational). No skid buffer.
// - Accepted pixel at (row r, col c):
//   - Window columns shift left.
//   - New right column = {lb2[c], lb1[c], s_data}, i.e. rows r-2, r-1, r.
//   - Then lb2[c] <= lb1[c] and lb1[c] <= s_data.
// - Output rule: if r>=2 && c>=2, next cycle m_valid=1 with centre pixel (r-1,c-1).
//   - Latency is exactly 1 cycle from acceptance.
//   - m_eol=1 iff c==IMG_W-1.
// - Hold rule: while m_valid && !m_ready, p0..p8, m_eol and m_valid stay stable.
// - On m_ready with no new qualifying pixel accepted, m_valid drops to 0 next cycle.
// - Back-to-back throughput: 1 window per cycle when s_valid=m_ready=1.
// - Counters:
//   - col wraps IMG_W-1 -> 0 and increments row.
//   - row wraps IMG_H-1 -> 0 on the frame's last pixel.
//   - The next pixel is (0,0) even without s_sof.
// - s_sof=1 on an accepted pixel forces it to (0,0), whatever the counter state. Mid-frame:
//   - The partial frame is abandoned.
//   - A pending m_valid window is still delivered.
//   - No window mixes rows across the resync.
//   - The row>=2 gating guarantees this.
// - s_sof with s_valid=0 or s_ready=0 is ignored.
// - Reset mid-frame: the pending window is discarded and the next accepted pixel is (0,0).
// CONFIGURATION
// - WIN_CNT_EN defined:
//   - win_cnt port present.
//   - Increments on each m_valid && m_ready handshake.
//   - Cleared on reset and on acceptance of an s_sof pixel.
//   - Saturates at 2^32-1.
//   - The (0,0) pixel produces no window, so there is no same-cycle conflict.
// - WIN_CNT_EN undefined: win_cnt port and its counter are absent; all other behaviour is identical.
// TESTING
// Bench parameters: DATA_W=8, IMG_W=5, IMG_H=4, pixel value = 10*r+c.
// - Full frame, s_valid=m_ready=1, s_sof on the first pixel:
//   - Exactly 6 windows.
//   - First window p0..p8 = 0,1,2,10,11,12,20,21,22, one cycle after pixel 22 is accepted.
//   - m_eol=1 on the windows centred at 13 and 23.
// - Backpressure: hold m_ready=0 for 3 cycles with window centre 12 pending:
//   - m_valid and p0..p8 stay stable, s_ready=0.
//   - No pixel is lost; the remaining windows follow in order.
// - Two consecutive frames, s_sof only on the first:
//   - 12 windows total.
//   - The second frame's first window again has p4=11.
// - Mid-frame resync: s_sof on the 8th pixel, then a full frame:
//   - No windows are emitted before row 2 of the new frame.
//   - First window p4=11.
// - Reset mid-frame: assert rst_n=0 for 1 cycle after 12 pixels:
//   - m_valid=0 and p0..p8=0 in the following cycle.
//   - The next full frame yields 6 correct windows.
// - With WIN_CNT_EN: win_cnt=6 after the first frame, 0 after the next s_sof pixel is accepted.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 window generator with two line buffers and valid/ready on both sides.
// Optional per-frame window counter on port win_cnt when WIN_CNT_EN is defined.
module window_3x3_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
`ifdef WIN_CNT_EN
    output logic [31:0]       win_cnt,
`endif
    output logic              m_eol
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_lb2 [IMG_W];
    logic [DATA_W-1:0] r_win [9];
    logic              r_m_valid;
    logic              r_m_eol;

    logic              w_accept;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_emit;
    logic [DATA_W-1:0] w_lb1_rd;
    logic [DATA_W-1:0] w_lb2_rd;

    assign s_ready    = rst_n && (!r_m_valid || m_ready);
    assign w_accept   = s_valid && s_ready;
    // An s_sof pixel is always position (0,0), regardless of the counters.
    assign w_col      = s_sof ? '0 : r_col;
    assign w_row      = s_sof ? '0 : r_row;
    assign w_col_last = (w_col == CW'(IMG_W - 1));
    assign w_row_last = (w_row == RW'(IMG_H - 1));
    assign w_emit     = (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign w_lb1_rd   = r_lb1[w_col];
    assign w_lb2_rd   = r_lb2[w_col];

    // Line buffers carry no reset; row gating keeps stale contents off the outputs.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
            r_m_valid <= 1'b0;
            r_m_eol   <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[3*i]   <= r_win[3*i+1];
                r_win[3*i+1] <= r_win[3*i+2];
            end
            r_win[2]  <= w_lb2_rd;
            r_win[5]  <= w_lb1_rd;
            r_win[8]  <= s_data;
            r_m_valid <= w_emit;
            r_m_eol   <= w_emit && w_col_last;
            r_col     <= w_col_last ? '0 : w_col + CW'(1);
            if (w_col_last) begin
                r_row <= w_row_last ? '0 : w_row + RW'(1);
            end else begin
                r_row <= w_row;
            end
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_eol   <= 1'b0;
        end
    end

`ifdef WIN_CNT_EN
    logic [31:0] r_win_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
        end else if (w_accept && s_sof) begin
            r_win_cnt <= '0;
        end else if (r_m_valid && m_ready && (r_win_cnt != '1)) begin
            r_win_cnt <= r_win_cnt + 32'd1;
        end
    end

    assign win_cnt = r_win_cnt;
`endif

    assign m_valid = r_m_valid;
    assign m_eol   = r_m_eol;
    assign p0      = r_win[0];
    assign p1      = r_win[1];
    assign p2      = r_win[2];
    assign p3      = r_win[3];
    assign p4      = r_win[4];
    assign p5      = r_win[5];
    assign p6      = r_win[6];
    assign p7      = r_win[7];
    assign p8      = r_win[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: directed and random pixel streams checked against an image-array model.
module tb_window_3x3_gen;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IMG_W  = 5;
    localparam int unsigned IMG_H  = 4;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic              s_sof;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic              m_eol;
`ifdef WIN_CNT_EN
    logic [31:0]       win_cnt;
`endif

    window_3x3_gen #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sof   (s_sof),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .p0      (p0),
        .p1      (p1),
        .p2      (p2),
        .p3      (p3),
        .p4      (p4),
        .p5      (p5),
        .p6      (p6),
        .p7      (p7),
        .p8      (p8),
`ifdef WIN_CNT_EN
        .win_cnt (win_cnt),
`endif
        .m_eol   (m_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] pv [9];
    assign pv[0] = p0;
    assign pv[1] = p1;
    assign pv[2] = p2;
    assign pv[3] = p3;
    assign pv[4] = p4;
    assign pv[5] = p5;
    assign pv[6] = p6;
    assign pv[7] = p7;
    assign pv[8] = p8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the current frame as an image, plus the window it implies.
    int                img [IMG_H][IMG_W];
    int                mr, mc;
    bit                exp_mv;
    bit                exp_eol;
    logic [DATA_W-1:0] exp_win [9];
    logic [31:0]       exp_wc;

    int                n_win;
    int                obs_c [$];
    bit                obs_e [$];
    logic [DATA_W-1:0] first_win [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int pix_val(input int k);
        return 10 * ((k / IMG_W) % IMG_H) + (k % IMG_W);
    endfunction

    task automatic drive(input bit v, input bit sof, input logic [DATA_W-1:0] d, input bit rdy,
                         output bit acc);
        bit hs;
        bit rst_edge;
        s_valid = v;
        s_sof   = sof;
        s_data  = d;
        m_ready = rdy;
        #1;
        chk("s_ready", {31'd0, s_ready}, {31'd0, rst_n && (!exp_mv || rdy)});
        rst_edge = !rst_n;
        acc      = rst_n && v && (!exp_mv || rdy);
        hs       = rst_n && exp_mv && rdy;
        if (hs) begin
            if (n_win == 0) for (int i = 0; i < 9; i++) first_win[i] = pv[i];
            obs_c.push_back(int'(p4));
            obs_e.push_back(m_eol);
            n_win++;
        end
        if (rst_edge) begin
            exp_mv  = 1'b0;
            exp_eol = 1'b0;
            for (int i = 0; i < 9; i++) exp_win[i] = '0;
            mr      = 0;
            mc      = 0;
            exp_wc  = '0;
        end else begin
            if (hs) begin
                exp_mv  = 1'b0;
                exp_eol = 1'b0;
                if (exp_wc != 32'hFFFF_FFFF) exp_wc++;
            end
            if (acc) begin
                if (sof) begin
                    mr     = 0;
                    mc     = 0;
                    exp_wc = '0;
                end
                img[mr][mc] = int'(d);
                if (mr >= 2 && mc >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            exp_win[3*i+j] = DATA_W'(img[mr-2+i][mc-2+j]);
                    exp_mv  = 1'b1;
                    exp_eol = (mc == IMG_W - 1);
                end
                mc++;
                if (mc == IMG_W) begin
                    mc = 0;
                    mr = (mr + 1) % IMG_H;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("m_valid", {31'd0, m_valid}, {31'd0, exp_mv});
        if (exp_mv || rst_edge) begin
            chk("m_eol", {31'd0, m_eol}, {31'd0, exp_eol});
            for (int i = 0; i < 9; i++) chk($sformatf("p%0d", i), 32'(pv[i]), 32'(exp_win[i]));
        end
`ifdef WIN_CNT_EN
        chk("win_cnt", win_cnt, exp_wc);
`endif
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b1, acc);
    endtask

    task automatic run_pixels(input int first, input int last, input bit sof_first,
                              input int p_valid, input int p_ready, input bit rnd);
        int                idx;
        int                cyc;
        bit                acc;
        bit                v;
        bit                rdy;
        logic [DATA_W-1:0] d;
        idx = first;
        cyc = 0;
        d   = rnd ? DATA_W'($urandom) : DATA_W'(pix_val(idx));
        while (idx <= last && cyc < 2000) begin
            v   = ($urandom_range(99) < p_valid);
            rdy = ($urandom_range(99) < p_ready);
            drive(v, sof_first && (idx == first), d, rdy, acc);
            if (acc) begin
                idx++;
                d = rnd ? DATA_W'($urandom) : DATA_W'(pix_val(idx));
            end
            cyc++;
        end
        if (idx <= last) chk("pixel_budget", idx, last + 1);
    endtask

    task automatic clear_obs();
        n_win = 0;
        obs_c.delete();
        obs_e.delete();
    endtask

    task automatic chk_centres(input string tag);
        int exp_c [6];
        exp_c = '{11, 12, 13, 21, 22, 23};
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_c%0d", tag, i), (i < obs_c.size()) ? obs_c[i] : -1, exp_c[i]);
        end
    endtask

    initial begin
        bit acc;
        int exp_first [9];
        exp_first = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        exp_mv  = 1'b0;
        exp_eol = 1'b0;
        exp_wc  = '0;
        mr      = 0;
        mc      = 0;
        for (int i = 0; i < 9; i++) exp_win[i] = '0;
        clear_obs();

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, acc);
        drive(1'b1, 1'b1, 8'd7, 1'b1, acc);
        rst_n = 1'b1;

        // Full frame at full rate
        clear_obs();
        run_pixels(0, 19, 1'b1, 100, 100, 1'b0);
        idle(2);
        chk("frame_windows", n_win, 6);
        for (int i = 0; i < 9; i++)
            chk($sformatf("first_p%0d", i), 32'(first_win[i]), exp_first[i]);
        chk_centres("frame");
        for (int i = 0; i < 6; i++)
            chk($sformatf("frame_eol%0d", i), (i < obs_e.size()) ? int'(obs_e[i]) : -1,
                (i == 2 || i == 5) ? 1 : 0);
`ifdef WIN_CNT_EN
        chk("win_cnt_frame", win_cnt, 32'd6);
`endif

        // Backpressure with centre 12 pending
        clear_obs();
        run_pixels(0, 0, 1'b1, 100, 100, 1'b0);
`ifdef WIN_CNT_EN
        chk("win_cnt_sof", win_cnt, 32'd0);
`endif
        run_pixels(1, 13, 1'b0, 100, 100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, DATA_W'(pix_val(14)), 1'b0, acc);
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_p4", 32'(p4), 32'd12);
        end
        run_pixels(14, 19, 1'b0, 100, 100, 1'b0);
        idle(2);
        chk("bp_windows", n_win, 6);
        chk_centres("bp");

        // Two frames, s_sof only on the first
        clear_obs();
        run_pixels(0, 39, 1'b1, 100, 100, 1'b0);
        idle(2);
        chk("two_frame_windows", n_win, 12);
        chk("second_frame_p4", (obs_c.size() > 6) ? obs_c[6] : -1, 11);

        // Mid-frame resync on the 8th pixel
        clear_obs();
        run_pixels(0, 6, 1'b1, 100, 100, 1'b0);
        run_pixels(0, 19, 1'b1, 100, 100, 1'b0);
        idle(2);
        chk("resync_windows", n_win, 6);
        chk("resync_first_p4", (obs_c.size() > 0) ? obs_c[0] : -1, 11);

        // Reset mid-frame, then a frame without s_sof
        clear_obs();
        run_pixels(0, 11, 1'b1, 100, 100, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, DATA_W'(pix_val(12)), 1'b1, acc);
        rst_n = 1'b1;
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        for (int i = 0; i < 9; i++) chk($sformatf("rst_p%0d", i), 32'(pv[i]), 32'd0);
        clear_obs();
        run_pixels(0, 19, 1'b0, 100, 100, 1'b0);
        idle(2);
        chk("post_rst_windows", n_win, 6);
        chk_centres("post_rst");

        // Random data with random valid/ready over three frames
        clear_obs();
        run_pixels(0, 59, 1'b1, 70, 60, 1'b1);
        idle(3);
        chk("random_windows", n_win, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
